// File: rtl/spi_pkg.sv
// Shared SPI definitions for the read master and the FPGA-side slave.
package spi_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_mst_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled,
// with single-cycle strobes on the cycles that launch each SCLK edge.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_en,
  output logic fall_en,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          phase_end_s;

  always_comb begin
    phase_end_s = (cnt_q == CW'(CLK_DIV - 1));
    rise_en     = en && !sclk_q && phase_end_s;
    fall_en     = en &&  sclk_q && phase_end_s;
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (phase_end_s) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_read_master.sv
// Mode-0 SPI read master: one start pulse reads one WORD_W-bit word, MSB first,
// and presents it on data_out with a single-cycle valid pulse.
module spi_read_master
  import spi_pkg::*;
#(
  parameter int WORD_W   = SPI_WORD_W,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              SCLK,
  output logic              CS_n,
  input  logic              MISO
);

  localparam int TMAX = (CS_SETUP > CS_HOLD) ?
                        ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                        ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(WORD_W + 1);

  spi_mst_state_t    state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              shift_en_s, rise_en_s, fall_en_s, sclk_s;

  assign shift_en_s = (state_q == SHIFT);

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk     (clk),
    .reset   (reset),
    .en      (shift_en_s),
    .rise_en (rise_en_s),
    .fall_en (fall_en_s),
    .sclk    (sclk_s)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          tmr_d     = '0;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      SETUP: begin
        if (tmr_q == TW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          tmr_d   = '0;
        end else begin
          tmr_d   = tmr_q + TW'(1);
        end
      end
      SHIFT: begin
        // bit_cnt counts rising edges; the falling edge after the last one ends the frame
        if (rise_en_s) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (fall_en_s) begin
          shift_d = {shift_q[WORD_W-2:0], MISO};
          if (bit_cnt_q == BW'(WORD_W)) begin
            state_d = HOLD;
            tmr_d   = '0;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (tmr_q == TW'(CS_HOLD - 1)) begin
          state_d    = GAP;
          tmr_d      = '0;
          data_out_d = shift_q;
          valid_d    = 1'b1;
        end else begin
          tmr_d      = tmr_q + TW'(1);
        end
      end
      GAP: begin
        if (tmr_q == TW'(CS_IDLE - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d   = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    // Chip select and busy are registered copies of the next state
    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign CS_n           = cs_n_q;
  assign SCLK           = sclk_s;

endmodule

// File: doc/spi_read_master.md
# spi_read_master

Synthesizable SPI master that reads 32-bit words from the FPGA-side SPI slave (MISO-only data path), running on the same single system clock. On a `start` pulse it lowers `CS_n`, generates exactly `WORD_W` SCLK periods in SPI mode 0, and shifts in `MISO` MSB first. It then presents the word on `data_out` with a one-cycle `data_out_valid` pulse. It replaces the behavioural master model with RTL that can serve as a loop-back checker and as a bridge master on hardware.

## Interface
- `WORD_W`, 32: bits per frame.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥2.
- `CS_SETUP`, 2: `clk` cycles from `CS_n` falling to the first SCLK phase; must be ≥1.
- `CS_HOLD`, 2: `clk` cycles from the last SCLK falling edge to `CS_n` rising; must be ≥1.
- `CS_IDLE`, 2: minimum `clk` cycles `CS_n` stays high after a frame before `busy` drops; must be ≥1.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one read frame; sampled only when `busy`=0.
- `busy`  out  1  frame in progress, including the CS_IDLE gap.
- `data_out`  out  WORD_W  last received word; holds until the next frame completes.
- `data_out_valid`  out  1  one-cycle pulse when `data_out` updates.
- `SCLK`  out  1  SPI clock; idles low (CPOL=0).
- `CS_n`  out  1  chip select, active low.
- `MISO`  in  1  serial data from the slave.

## Operation
- Reset values, all registered: `CS_n`=1, `SCLK`=0, `busy`=0, `data_out_valid`=0, `data_out`=0, state IDLE.
- **IDLE**
  - `start`=1 → SETUP.
  - `start` while busy is ignored, not queued.
- **SETUP**: `CS_n`=0, `SCLK`=0 for CS_SETUP cycles → SHIFT.
- **SHIFT**
  - `WORD_W` SCLK periods; each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - Mode 0 (CPHA=0): `MISO` is sampled on the last `clk` cycle of each high phase, the edge that drives `SCLK` 1→0.
  - Sampled bits shift into the LSB of the shift register, so the first bit lands in MSB position.
  - After the last period's falling edge → HOLD.
- **HOLD**: `CS_n`=0, `SCLK`=0 for CS_HOLD cycles → GAP.
- **GAP**
  - On entry: `CS_n`←1, `data_out`←shift register, `data_out_valid`=1 for that one cycle.
  - Stays in GAP for CS_IDLE cycles, then → IDLE with `busy`=0.
- Bit counter: width $clog2(WORD_W+1). Half-period counter: width $clog2(CLK_DIV). Both wrap to 0 at each phase/frame start; no overflow is possible.
- Each frame produces exactly WORD_W rising SCLK edges. `SCLK` never toggles while `CS_n`=1.
- Reset mid-frame:
  - Next edge returns all outputs to their reset values.
  - No `data_out_valid` pulse for the aborted frame.
  - The partial word is discarded.
- `reset` and `start` in the same cycle: reset wins.

## Timing
- `start` sampled at edge t0 → `busy`=1 and `CS_n`=0 from t0+1.
- First SCLK rising edge at t0+1+CS_SETUP+CLK_DIV.
- `data_out_valid` at t0+L, where L = 1+CS_SETUP+2·CLK_DIV·WORD_W+CS_HOLD. With defaults L=261.
- `busy` falls at t0+L+CS_IDLE (263 with defaults). `start` held high launches the next frame at that edge.
- Minimum `CS_n` high time between frames is CS_IDLE+1 cycles.
- `MISO` must be stable during the last `clk` cycle of each SCLK high phase. The slave updates `MISO` after SCLK falls, giving CLK_DIV−1 cycles of margin.

## Structure
- Package `spi_pkg`:
  - state enum `spi_mst_state_t` {IDLE, SETUP, SHIFT, HOLD, GAP};
  - `SPI_WORD_W`=32;
  - shared with the slave side.
- One sub-module, `spi_sclk_div`:
  - half-period counter producing `rise_en` and `fall_en` strobes plus the registered `SCLK` level;
  - enabled only in SHIFT.
- Top level holds the FSM, bit counter, shift register and output registers.

## Test plan
- **Reset:** hold `reset` 10 cycles.
  - Outputs must be `CS_n`=1, `SCLK`=0, `busy`=0, `data_out`=0, `data_out_valid`=0.
  - No SCLK edges.
- **Single read:** behavioural mode-0 slave loaded with 0xA5A55A5A; pulse `start`.
  - Exactly 32 SCLK rises.
  - `data_out_valid` at start+261 with `data_out`=0xA5A55A5A.
  - `busy` low at start+263.
- **Bit order:** slave words 0x80000001, then 0x00000000, then 0xFFFFFFFF.
  - `data_out` must match each word exactly, confirming MSB first and no stuck bits.
- **Back-to-back:** `start` held high; slave queue 0xDEADBEEF, 0x00000001.
  - Two valid pulses, 263 cycles apart, carrying those values.
  - `CS_n` high for exactly 3 cycles between the frames.
- **Ignored start:** pulse `start` at bits 5 and 20 of a frame.
  - Exactly one frame and one valid pulse.
  - No extra `CS_n` assertion.
- **Reset mid-shift:** assert `reset` after the 10th SCLK rise.
  - Next cycle `CS_n`=1 and `SCLK`=0; no valid pulse.
  - A following `start` reads 0x12345678 correctly.
  - Scoreboard checks every frame against the slave's sent queue.
